// File: rtl/sys_reset_seq.sv
// sys_reset_seq: power-on/button reset sequencer with a divided Z80 clock and one-clk enable
module sys_reset_seq #(
  parameter int HOLD_CYCLES = 8,
  parameter int CPU_DIV = 2,
  parameter int CPU_HOLD = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic button_n,
  output logic sys_reset,
  output logic cpu_clk,
  output logic cpu_clk_en,
  output logic cpu_reset_n,
  output logic ready
);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int CW = $clog2(CPU_HOLD + 1);
  localparam int DW = $clog2(CPU_DIV);
  localparam int BW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [1:0] {ASSERT, SYS_RUN, RUN} state_t;
  state_t state, state_nx;
  logic [1:0] run_sync, btn_sync;
  logic [DW-1:0] div_ctr;
  logic [BW-1:0] db_ctr;
  logic [HW-1:0] hold_ctr;
  logic [CW-1:0] cpu_ctr;
  logic pressed, div_wrap;
  assign pressed = db_ctr == BW'(DEBOUNCE_CYCLES);
  assign div_wrap = div_ctr == DW'(CPU_DIV - 1);
  always_comb begin
    state_nx = pressed ? ASSERT
             : state == ASSERT ? (hold_ctr == HW'(HOLD_CYCLES - 1) ? SYS_RUN : ASSERT)
             : state == SYS_RUN ? ((cpu_clk_en && cpu_ctr == CW'(CPU_HOLD - 1)) ? RUN : SYS_RUN)
             : RUN;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_sync <= '0;
      btn_sync <= '0;
      div_ctr <= '0;
      db_ctr <= '0;
      hold_ctr <= '0;
      cpu_ctr <= '0;
      state <= ASSERT;
      sys_reset <= 1'b1;
      cpu_clk <= 1'b0;
      cpu_clk_en <= 1'b0;
      cpu_reset_n <= 1'b0;
      ready <= 1'b0;
    end else begin
      run_sync <= {run_sync[0], 1'b1};
      btn_sync <= {btn_sync[0], button_n};
      if (run_sync[1]) begin
        div_ctr <= div_wrap ? '0 : div_ctr + 1'b1;
        cpu_clk <= div_wrap ? 1'b1 : div_ctr == DW'(CPU_DIV / 2 - 1) ? 1'b0 : cpu_clk;
        cpu_clk_en <= div_wrap;
        db_ctr <= btn_sync[1] ? '0 : pressed ? db_ctr : db_ctr + 1'b1;
        hold_ctr <= pressed ? '0 : state == ASSERT ? hold_ctr + 1'b1 : hold_ctr;
        cpu_ctr <= state == ASSERT ? '0 : (state == SYS_RUN && cpu_clk_en) ? cpu_ctr + 1'b1 : cpu_ctr;
        state <= state_nx;
        sys_reset <= state_nx == ASSERT;
        cpu_reset_n <= state_nx == RUN;
        ready <= state_nx == RUN;
      end
    end
  end
endmodule

// File: tb/tb_sys_reset_seq.sv
// tb_sys_reset_seq: randomized bench for sys_reset_seq (CPU_DIV 2 and 4) against an edge-count model
module tb_sys_reset_seq;
  localparam int HOLD = 8;
  localparam int CH = 4;
  localparam int DB = 16;
  localparam int DIV0 = 2;
  localparam int DIV1 = 4;
  logic clk, reset_n;
  logic [1:0] btn, d_sys, d_clk, d_en, d_cpun, d_rdy;
  int n_chk, n_pass, t;
  bit chk_on;
  int run_low [2];
  int r_edge [2];
  int pulses [2];
  logic [1:0] bd1, bd2, m_sys, m_clk, m_en, m_cpun;
  bit pressed_prev;
  int div;

  sys_reset_seq #(.HOLD_CYCLES(HOLD), .CPU_DIV(DIV0), .CPU_HOLD(CH), .DEBOUNCE_CYCLES(DB)) u0 (
    .clk(clk), .reset_n(reset_n), .button_n(btn[0]), .sys_reset(d_sys[0]), .cpu_clk(d_clk[0]),
    .cpu_clk_en(d_en[0]), .cpu_reset_n(d_cpun[0]), .ready(d_rdy[0]));
  sys_reset_seq #(.HOLD_CYCLES(HOLD), .CPU_DIV(DIV1), .CPU_HOLD(CH), .DEBOUNCE_CYCLES(DB)) u1 (
    .clk(clk), .reset_n(reset_n), .button_n(btn[1]), .sys_reset(d_sys[1]), .cpu_clk(d_clk[1]),
    .cpu_clk_en(d_en[1]), .cpu_reset_n(d_cpun[1]), .ready(d_rdy[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(string name, logic act, logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b (edge %0d, time %0t)", name, act, exp, t, $time);
  endfunction

  task automatic wait_until(input int n);
    for (int k = 0; k < 2000 && t != n; k++) @(negedge clk);
    if (t != n) begin
      n_chk++;
      $display("FAIL wait_until: at edge %0d, required edge %0d", t, n);
    end
  endtask

  // t = rising edges since reset release; r_edge = last edge that saw the button pressed
  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      t = 0;
      for (int i = 0; i < 2; i++) begin
        run_low[i] = 0;
        r_edge[i] = 2;
        pulses[i] = 0;
      end
      bd1 = '0;
      bd2 = '0;
      m_sys = 2'b11;
      m_clk = '0;
      m_en = '0;
      m_cpun = '0;
    end else begin
      t = t + 1;
      for (int i = 0; i < 2; i++) begin
        div = i == 0 ? DIV0 : DIV1;
        if (t >= 3) begin
          pressed_prev = run_low[i] >= DB;
          if (pressed_prev) begin
            r_edge[i] = t;
            pulses[i] = 0;
          end else if (t > r_edge[i] + HOLD && m_en[i]) pulses[i]++;
          m_sys[i] = (t - r_edge[i]) < HOLD;
          m_cpun[i] = !m_sys[i] && pulses[i] >= CH;
          m_clk[i] = t >= div + 2 && (t - 2) % div < div / 2;
          m_en[i] = t >= div + 2 && (t - 2) % div == 0;
          run_low[i] = bd2[i] ? 0 : run_low[i] + 1;
        end
        bd2[i] = bd1[i];
        bd1[i] = btn[i];
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_on) for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d.sys_reset", i), d_sys[i], m_sys[i]);
      chk($sformatf("u%0d.cpu_clk", i), d_clk[i], m_clk[i]);
      chk($sformatf("u%0d.cpu_clk_en", i), d_en[i], m_en[i]);
      chk($sformatf("u%0d.cpu_reset_n", i), d_cpun[i], m_cpun[i]);
      chk($sformatf("u%0d.ready", i), d_rdy[i], m_cpun[i]);
    end
  end

  task automatic power_on(input bit simul);
    wait_until(3); chk("u0.cpu_clk@3", d_clk[0], 1'b0);
    wait_until(4); chk("u0.cpu_clk@4", d_clk[0], 1'b1); chk("u0.cpu_clk_en@4", d_en[0], 1'b1);
    if (simul) btn[1] = 1'b0;
    wait_until(5); chk("u0.cpu_clk_en@5", d_en[0], 1'b0);
    wait_until(6); chk("u1.cpu_clk@6", d_clk[1], 1'b1); chk("u1.cpu_clk_en@6", d_en[1], 1'b1);
    wait_until(7); chk("u1.cpu_clk@7", d_clk[1], 1'b1); chk("u1.cpu_clk_en@7", d_en[1], 1'b0);
    wait_until(8); chk("u1.cpu_clk@8", d_clk[1], 1'b0);
    wait_until(9); chk("u0.sys_reset@9", d_sys[0], 1'b1);
    wait_until(10); chk("u0.sys_reset@10", d_sys[0], 1'b0); chk("u1.sys_reset@10", d_sys[1], 1'b0);
    wait_until(16); chk("u0.cpu_reset_n@16", d_cpun[0], 1'b0);
    wait_until(17); chk("u0.cpu_reset_n@17", d_cpun[0], 1'b1); chk("u0.ready@17", d_rdy[0], 1'b1);
    wait_until(22); chk("u1.cpu_reset_n@22", d_cpun[1], 1'b0); chk("u1.sys_reset@22", d_sys[1], 1'b0);
    wait_until(23);
    if (simul) begin
      chk("u1.sys_reset@23 simul", d_sys[1], 1'b1);
      chk("u1.cpu_reset_n@23 simul", d_cpun[1], 1'b0);
    end else chk("u1.cpu_reset_n@23", d_cpun[1], 1'b1);
  endtask

  initial begin
    btn = 2'b11;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    chk_on = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset sys_reset", d_sys[0], 1'b1);
    chk("reset cpu_reset_n", d_cpun[0], 1'b0);
    chk("reset cpu_clk", d_clk[0], 1'b0);
    chk("reset cpu_clk_en", d_en[0], 1'b0);
    chk("reset ready", d_rdy[0], 1'b0);
    reset_n = 1'b1;
    power_on(1'b1);
    wait_until(30); chk("u1.cpu_reset_n held@30", d_cpun[1], 1'b0);
    wait_until(40); btn[1] = 1'b1;
    wait_until(220); btn[0] = 1'b0;
    wait_until(230); btn[0] = 1'b1;
    wait_until(249);
    chk("glitch u0.ready", d_rdy[0], 1'b1);
    chk("glitch u0.sys_reset", d_sys[0], 1'b0);
    wait_until(250); btn[0] = 1'b0;
    wait_until(268); chk("press u0.sys_reset@18", d_sys[0], 1'b0);
    wait_until(269); chk("press u0.sys_reset@19", d_sys[0], 1'b1); chk("press u0.cpu_reset_n@19", d_cpun[0], 1'b0);
    wait_until(280); chk("press u0.cpu_clk@280", d_clk[0], 1'b1);
    wait_until(281); chk("press u0.cpu_clk@281", d_clk[0], 1'b0);
    wait_until(290); btn[0] = 1'b1;
    wait_until(300); chk("release u0.sys_reset@300", d_sys[0], 1'b1);
    wait_until(301); chk("release u0.sys_reset@301", d_sys[0], 1'b0);
    wait_until(308); chk("release u0.cpu_reset_n@308", d_cpun[0], 1'b0);
    wait_until(309); chk("release u0.cpu_reset_n@309", d_cpun[0], 1'b1);
    wait_until(320);
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    wait_until(12);
    #2 reset_n = 1'b0;
    #1;
    chk("async sys_reset", d_sys[0], 1'b1);
    chk("async cpu_clk", d_clk[0], 1'b0);
    chk("async cpu_clk_en", d_en[0], 1'b0);
    chk("async cpu_reset_n", d_cpun[0], 1'b0);
    chk("async ready", d_rdy[0], 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    power_on(1'b0);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) if ($urandom_range(0, 29) == 0) btn[i] = ~btn[i];
      if ($urandom_range(0, 399) == 0) begin
        #1 reset_n = 1'b0;
        #1 chk("rand async sys_reset", d_sys[0], 1'b1);
        chk("rand async cpu_reset_n", d_cpun[1], 1'b0);
        #1 reset_n = 1'b1;
      end
    end
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sys_reset_seq.md
# sys_reset_seq

Reset sequencer and CPU clock generator at the root of the Z80 computer. It runs on the 25.175 MHz system clock, produces the system reset consumed by `top`, and produces the divided CPU clock with a one-cycle clock-enable. It holds the Z80 RESET line low for a minimum number of CPU clocks after the system logic is released. It also accepts a debounced front-panel reset button that re-runs the sequence without power-cycling.

## Interface
- `HOLD_CYCLES`, 8: clk cycles `sys_reset` stays high after reset release; ≥1.
- `CPU_DIV`, 2: clk cycles per CPU clock period; even, ≥2.
- `CPU_HOLD`, 4: `cpu_clk_en` pulses `cpu_reset_n` stays low after `sys_reset` falls; ≥3 (Z80 minimum).
- `DEBOUNCE_CYCLES`, 16: consecutive synchronized-low clk cycles before the button counts as pressed; ≥1.
- `clk`  in  1  system clock, 25.175 MHz.
- `reset_n`  in  1  power-on reset. One clock; reset is asynchronous and active-low.
- `button_n`  in  1  asynchronous front-panel reset button, active-low.
- `sys_reset`  out  1  active-high reset to system logic; deasserts synchronously.
- `cpu_clk`  out  1  registered CPU clock, 50 % duty.
- `cpu_clk_en`  out  1  one-clk pulse, high in each clk cycle in which `cpu_clk` is high for its first clk cycle.
- `cpu_reset_n`  out  1  Z80 RESET, active-low.
- `ready`  out  1  high once the full sequence has completed.

## Operation
- **Asynchronous reset** (`reset_n` low): all registers clear immediately.
  - Reset values: `sys_reset`=1, `cpu_reset_n`=0, `cpu_clk`=0, `cpu_clk_en`=0, `ready`=0.
  - Internal state: `run_sync`=00, `div_ctr`=0, state ASSERT, all counters 0.
- **Release synchronizer**: 2-flop shift of constant 1 into `run_sync`, cleared asynchronously by `reset_n`. All logic below advances only while `run_sync[1]`=1.
- **Divider**: `div_ctr` counts 0..CPU_DIV-1 and wraps.
  - At `div_ctr`=CPU_DIV/2-1, `cpu_clk`<=0.
  - At `div_ctr`=CPU_DIV-1, `cpu_clk`<=1 and `cpu_clk_en`<=1.
  - Otherwise `cpu_clk_en`<=0.
  - The divider runs in every state, including button reset. The Z80 needs clocks while RESET is low.
- **Button**: 2-flop synchronizer, then `db_ctr`.
  - `db_ctr` increments while the synchronized button is low and saturates at DEBOUNCE_CYCLES.
  - `db_ctr` clears on any synchronized high.
  - `pressed` = (`db_ctr`==DEBOUNCE_CYCLES). Release takes effect immediately (no release debounce).
- **State machine** (`hold_ctr` width `$clog2(HOLD_CYCLES+1)`; `cpu_ctr` width `$clog2(CPU_HOLD+1)`):
  - ASSERT: `sys_reset`=1, `cpu_reset_n`=0, `ready`=0.
    - `hold_ctr` increments each enabled edge.
    - On the edge where `hold_ctr`=HOLD_CYCLES-1: go to SYS_RUN and clear `cpu_ctr`.
  - SYS_RUN: `sys_reset`=0, `cpu_reset_n`=0.
    - Each edge that samples `cpu_clk_en`=1 increments `cpu_ctr`.
    - On the edge sampling the CPU_HOLD-th such pulse: go to RUN.
  - RUN: `sys_reset`=0, `cpu_reset_n`=1, `ready`=1. Terminal until reset or button.
- **Button priority**: `pressed`=1 in any state forces ASSERT on the next edge and clears `hold_ctr`.
  - This holds while pressed; the hold count starts only after release.
  - `pressed` overrides a simultaneous SYS_RUN→RUN or ASSERT→SYS_RUN transition.
- **Outputs**: all registered, decoded from next state. No combinational path from any input to any output.

## Timing
- Edge 1 is the first rising `clk` with `reset_n` high.
  - Edges 1–2: synchronizer.
  - Logic runs from edge 3.
- **Defaults** (HOLD 8, DIV 2, CPU_HOLD 4):
  - `cpu_clk` rises at edges 4, 6, 8, …
  - `cpu_clk_en` is high after edges 4, 6, 8, …
  - `sys_reset` falls at edge 10.
  - `cpu_clk_en` is sampled at edges 11, 13, 15, 17.
  - `cpu_reset_n` and `ready` rise at edge 17.
- **General**:
  - `sys_reset` falls at edge 2+HOLD_CYCLES.
  - `cpu_reset_n` rises CPU_HOLD enable pulses later.
- **Button**:
  - `pressed` asserts 2+DEBOUNCE_CYCLES edges after `button_n` falls.
  - `sys_reset` and `cpu_reset_n` assert one edge after that.
- **`reset_n` low mid-operation**: outputs return to reset values within the same cycle (asynchronous). The sequence restarts from edge 1 on release.
- `reset_n` pulses of any width are honoured; no minimum width.

## Test plan
- **Power-on**: `reset_n` low for 5 clk, then high.
  - `sys_reset` falls at edge 10.
  - `cpu_clk` rises at edges 4, 6, 8, ….
  - `cpu_reset_n` and `ready` rise at edge 17.
  - Neither changes afterwards for 200 clk.
- **Divider, CPU_DIV=4**:
  - `cpu_clk` period is 4 clk with 2 high and 2 low.
  - `cpu_clk_en` is exactly one clk wide per period, aligned to the `cpu_clk` rise.
  - `cpu_reset_n` rises after 4 sampled pulses following the `sys_reset` fall.
- **Button glitch**: `button_n` low for 10 clk in RUN → no output change.
- **Button press**: `button_n` low for 40 clk in RUN.
  - `sys_reset`=1 and `cpu_reset_n`=0 at edge 19 after the fall.
  - `cpu_clk` keeps toggling.
  - After release, `sys_reset` falls 8 edges later and `cpu_reset_n` rises 4 pulses after that.
- **Async reset mid-SYS_RUN**: drop `reset_n` between edges 12 and 13.
  - All outputs take reset values immediately, before edge 13.
  - On release, the full power-on sequence repeats with identical edge numbers.
- **Simultaneous events**: `pressed` asserts on the same edge as the 4th `cpu_clk_en` sample → state is ASSERT and `cpu_reset_n` never goes high.
